// File: rtl/alu_dual_exec_ctrl.sv
// Dual-pass ALU sequencer: runs each legal operation twice through a shared ALU
// (second pass with swapped operands for commutative ops) and flags any disagreement.
module alu_dual_exec_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [3:0]       req_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_fault,
    output logic             rsp_illegal,
    output logic             fault_sticky,
    output logic [CNT_W-1:0] fault_cnt,
    input  logic             fault_clear
);

    localparam logic [3:0] OpSub = 4'b0001;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StExec1 = 2'd1,
        StExec2 = 2'd2,
        StResp  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      r1_q, r1_d;
    logic             z1_q, z1_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_fault_q, rsp_fault_d;
    logic             rsp_illegal_q, rsp_illegal_d;
    logic             fault_sticky_q, fault_sticky_d;
    logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;

    logic req_legal;
    logic mismatch;

    assign req_legal = (req_op[3:2] == 2'b00);
    assign mismatch  = (state_q == StExec2) && ((alu_result != r1_q) || (alu_zero != z1_q));

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        r1_d          = r1_q;
        z1_d          = z1_q;
        rsp_result_d  = rsp_result_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_fault_d   = rsp_fault_q;
        rsp_illegal_d = rsp_illegal_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_legal) begin
                        a_d     = req_a;
                        b_d     = req_b;
                        op_d    = req_op;
                        state_d = StExec1;
                    end else begin
                        rsp_result_d  = 32'd0;
                        rsp_zero_d    = 1'b1;
                        rsp_fault_d   = 1'b0;
                        rsp_illegal_d = 1'b1;
                        state_d       = StResp;
                    end
                end
            end
            StExec1: begin
                r1_d    = alu_result;
                z1_d    = alu_zero;
                state_d = StExec2;
            end
            StExec2: begin
                rsp_result_d  = r1_q;
                rsp_zero_d    = z1_q;
                rsp_fault_d   = mismatch;
                rsp_illegal_d = 1'b0;
                state_d       = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A mismatch on the same edge as a clear wins, leaving one recorded fault.
    always_comb begin
        fault_sticky_d = fault_sticky_q;
        fault_cnt_d    = fault_cnt_q;
        if (mismatch) begin
            fault_sticky_d = 1'b1;
            if (fault_clear) begin
                fault_cnt_d = CNT_W'(1);
            end else if (fault_cnt_q != {CNT_W{1'b1}}) begin
                fault_cnt_d = fault_cnt_q + CNT_W'(1);
            end
        end else if (fault_clear) begin
            fault_sticky_d = 1'b0;
            fault_cnt_d    = '0;
        end
    end

    // Second pass swaps operands for commutative ops so a stuck input lane shows up.
    always_comb begin
        alu_a    = 32'd0;
        alu_b    = 32'd0;
        alu_ctrl = 4'b0000;
        unique case (state_q)
            StExec1: begin
                alu_a    = a_q;
                alu_b    = b_q;
                alu_ctrl = op_q;
            end
            StExec2: begin
                alu_a    = (op_q == OpSub) ? a_q : b_q;
                alu_b    = (op_q == OpSub) ? b_q : a_q;
                alu_ctrl = op_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            a_q            <= 32'd0;
            b_q            <= 32'd0;
            op_q           <= 4'd0;
            r1_q           <= 32'd0;
            z1_q           <= 1'b0;
            rsp_result_q   <= 32'd0;
            rsp_zero_q     <= 1'b0;
            rsp_fault_q    <= 1'b0;
            rsp_illegal_q  <= 1'b0;
            fault_sticky_q <= 1'b0;
            fault_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            r1_q           <= r1_d;
            z1_q           <= z1_d;
            rsp_result_q   <= rsp_result_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_fault_q    <= rsp_fault_d;
            rsp_illegal_q  <= rsp_illegal_d;
            fault_sticky_q <= fault_sticky_d;
            fault_cnt_q    <= fault_cnt_d;
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign rsp_valid    = (state_q == StResp);
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_fault    = rsp_fault_q;
    assign rsp_illegal  = rsp_illegal_q;
    assign fault_sticky = fault_sticky_q;
    assign fault_cnt    = fault_cnt_q;

endmodule

// File: tb/tb_alu_dual_exec_ctrl.sv
// Bench for alu_dual_exec_ctrl: behavioural ALU with pass-2 fault injection,
// vector table plus directed backpressure, clear/mismatch, reset and saturation sequences.
module tb_alu_dual_exec_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready;
    logic [31:0]      req_a, req_b;
    logic [3:0]       req_op;
    logic [31:0]      alu_a, alu_b;
    logic [3:0]       alu_ctrl;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic             rsp_valid, rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_zero, rsp_fault, rsp_illegal;
    logic             fault_sticky;
    logic [CNT_W-1:0] fault_cnt;
    logic             fault_clear;

    logic        inj_en;
    logic [31:0] inj_a;

    int n_tests = 0;
    int n_fail  = 0;

    logic [CNT_W-1:0] cnt_exp = '0;
    logic             sticky_exp = 1'b0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          inj;
        logic [31:0] res;
        bit          zero;
        bit          fault;
        bit          ill;
    } vec_t;

    vec_t sb_q[$];
    vec_t vecs[9];

    always #5 clk = ~clk;

    alu_dual_exec_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_fault   (rsp_fault),
        .rsp_illegal (rsp_illegal),
        .fault_sticky(fault_sticky),
        .fault_cnt   (fault_cnt),
        .fault_clear (fault_clear)
    );

    // Reference ALU; forced to zero when the driven a-operand matches inj_a.
    always_comb begin
        alu_result = 32'd0;
        case (alu_ctrl)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0010: alu_result = alu_a & alu_b;
            4'b0011: alu_result = alu_a | alu_b;
            default: alu_result = 32'd0;
        endcase
        if (inj_en && alu_a == inj_a) alu_result = 32'd0;
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_rsp(input string tag, input vec_t e);
        chk({tag, "_result"}, rsp_result, e.res);
        chk({tag, "_zero"}, 32'(rsp_zero), 32'(e.zero));
        chk({tag, "_fault"}, 32'(rsp_fault), 32'(e.fault));
        chk({tag, "_illegal"}, 32'(rsp_illegal), 32'(e.ill));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_result"}, rsp_result, 32'd0);
        chk({tag, "_rsp_flags"}, {29'd0, rsp_zero, rsp_fault, rsp_illegal}, 32'd0);
        chk({tag, "_fault_sticky"}, 32'(fault_sticky), 32'd0);
        chk({tag, "_fault_cnt"}, 32'(fault_cnt), 32'd0);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'd0);
    endtask

    // Full transaction: accept, per-pass ALU checks, fixed latency, optional hold, handshake.
    task automatic run_op(input vec_t v, input int hold, input bit clr_e2, input bit full);
        bit   legal;
        vec_t e;
        legal = (v.op[3:2] == 2'b00);
        @(negedge clk);
        if (full) chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_a     = v.a;
        req_b     = v.b;
        req_op    = v.op;
        inj_en    = v.inj;
        inj_a     = v.b;
        sb_q.push_back(v);
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_op    = 4'($urandom_range(0, 15));
        if (legal) begin
            if (full) begin
                chk("exec1_alu_a", alu_a, v.a);
                chk("exec1_alu_b", alu_b, v.b);
                chk("exec1_alu_ctrl", 32'(alu_ctrl), 32'(v.op));
                chk("exec1_rsp_valid", 32'(rsp_valid), 32'd0);
            end
            @(negedge clk);
            if (full) begin
                chk("exec2_alu_a", alu_a, (v.op == 4'b0001) ? v.a : v.b);
                chk("exec2_alu_b", alu_b, (v.op == 4'b0001) ? v.b : v.a);
                chk("exec2_alu_ctrl", 32'(alu_ctrl), 32'(v.op));
                chk("exec2_rsp_valid", 32'(rsp_valid), 32'd0);
            end
            if (clr_e2) fault_clear = 1'b1;
            @(negedge clk);
            fault_clear = 1'b0;
            if (v.fault) begin
                sticky_exp = 1'b1;
                if (clr_e2) cnt_exp = CNT_W'(1);
                else if (cnt_exp != {CNT_W{1'b1}}) cnt_exp = cnt_exp + CNT_W'(1);
            end else if (clr_e2) begin
                sticky_exp = 1'b0;
                cnt_exp    = '0;
            end
        end else begin
            chk("illegal_alu_ctrl", 32'(alu_ctrl), 32'd0);
            chk("illegal_alu_a", alu_a, 32'd0);
        end
        chk("rsp_valid_latency", 32'(rsp_valid), 32'd1);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        if (full) chk_rsp("rsp", e);
        chk("fault_sticky", 32'(fault_sticky), 32'(sticky_exp));
        chk("fault_cnt", 32'(fault_cnt), 32'(cnt_exp));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_op    = 4'b0010;
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk_rsp("hold", e);
        end
        req_valid = 1'b0;
        inj_en    = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("back_to_idle", 32'(req_ready), 32'd1);
        chk("rsp_valid_dropped", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{4'b0000, 32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'b0001, 32'd9, 32'd9, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'b0011, 32'hF0, 32'h0F, 1'b1, 32'hFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{4'b0010, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 32'h0F000F00, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{4'b0000, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{4'b0001, 32'd3, 32'd5, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{4'b0111, 32'd5, 32'd6, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{4'b1111, 32'd1, 32'd2, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{4'b0000, 32'd1, 32'd2, 1'b1, 32'd3, 1'b0, 1'b1, 1'b0};

        rst         = 1'b1;
        req_valid   = 1'b0;
        req_a       = 32'd0;
        req_b       = 32'd0;
        req_op      = 4'd0;
        rsp_ready   = 1'b0;
        fault_clear = 1'b0;
        inj_en      = 1'b0;
        inj_a       = 32'd0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_op(vecs[i], 0, 1'b0, 1'b1);

        // Backpressure with ignored request traffic, then clear colliding with a mismatch.
        run_op(vecs[0], 5, 1'b0, 1'b1);
        chk("cnt_before_clr", 32'(fault_cnt), 32'd2);
        run_op(vecs[2], 0, 1'b1, 1'b1);
        chk("clr_mismatch_cnt", 32'(fault_cnt), 32'd1);
        chk("clr_mismatch_sticky", 32'(fault_sticky), 32'd1);

        @(negedge clk);
        fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0;
        sticky_exp  = 1'b0;
        cnt_exp     = '0;
        chk("clear_cnt", 32'(fault_cnt), 32'd0);
        chk("clear_sticky", 32'(fault_sticky), 32'd0);

        // Fault then reset during EXEC2: operation abandoned, everything back to reset values.
        run_op(vecs[8], 0, 1'b0, 1'b1);
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = 32'd5;
        req_b     = 32'd7;
        req_op    = 4'b0000;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_exec2_alu_a", alu_a, 32'd7);
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        cnt_exp    = '0;
        sticky_exp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        run_op(vecs[0], 0, 1'b0, 1'b1);

        // Saturation of the fault counter.
        for (int i = 0; i < (1 << CNT_W) + 2; i++) run_op(vecs[8], 0, 1'b0, 1'b0);
        chk("sat_cnt", 32'(fault_cnt), 32'((1 << CNT_W) - 1));
        chk("sat_sticky", 32'(fault_sticky), 32'd1);
        run_op(vecs[2], 0, 1'b0, 1'b1);
        chk("sat_no_wrap", 32'(fault_cnt), 32'((1 << CNT_W) - 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
